// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter (and the future receiver).
//   - PARITY_* : parity-mode encodings for the PARITY_MODE parameter
//   - ST_*     : FSM state encoding used by uart_tx_param
//   - frame_bits() : number of serial bit periods in one frame
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Start bit + data bits + optional parity bit + stop bits.
  function automatic int frame_bits(input int data_w, input int parity_mode, input int stop_bits);
    return 1 + data_w + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 while en=1 and raises tick
// (combinationally) on the terminal count, wrapping back to 0.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   en    in  count enable (0 freezes the counter)
//   clr   in  synchronous clear, has priority over en
//   tick  out terminal-count strobe, only while en=1
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;

  assign tick = en && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB-first,
// optional parity bit, then STOP_BITS stop bits, CLKS_PER_BIT clocks per bit.
// Optional one-entry holding buffer for back-to-back frames: define
// UART_TX_BUF_EN (adds the buf_full output).
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   enable   in  1 = run, 0 = freeze all state and outputs
//   start    in  send request, sampled while enable=1
//   data     in  word to send, captured when start is accepted
//   busy     out frame in progress
//   done     out one-cycle pulse after the last stop bit
//   buf_full out holding buffer occupied (UART_TX_BUF_EN only)
//   tx       out serial line, idle high, registered
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = PARITY_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
`ifdef UART_TX_BUF_EN
  output logic              buf_full,
`endif
  output logic              tx
);

  localparam int IDX_W = $clog2(DATA_W);

  logic [2:0]        state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_reg;
  logic [IDX_W-1:0]  bit_idx_reg;

  logic              run;
  logic              bit_tick;
  logic              accept;
  logic              restart;
  logic              last_data;
  logic              last_stop;
  logic [DATA_W-1:0] load_word;
  logic              tx_next;
  logic              busy_next;
  logic              done_next;

  function automatic logic frame_parity(input logic [DATA_W-1:0] word);
    return (PARITY_MODE == PARITY_ODD) ? ~^word : ^word;
  endfunction

  assign run       = enable && (state_reg inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
  assign accept    = enable && start && (state_reg == ST_IDLE);
  assign last_data = (bit_idx_reg == IDX_W'(DATA_W - 1));
  assign last_stop = (bit_idx_reg == IDX_W'(STOP_BITS - 1));

`ifdef UART_TX_BUF_EN
  logic [DATA_W-1:0] hold_reg;
  logic              hold_full_reg;
  logic              restart_done_reg;

  // End of the last stop bit with a word waiting: launch it directly.
  assign restart   = bit_tick && (state_reg == ST_STOP) && last_stop && hold_full_reg;
  assign load_word = accept ? data : hold_reg;
  assign buf_full  = hold_full_reg;
  // Delay the restart's done by one cycle so it lines up with the
  // non-buffered case (one cycle after the last stop period).
  assign done_next = (state_reg == ST_DONE) || restart_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg         <= '0;
      hold_full_reg    <= 1'b0;
      restart_done_reg <= 1'b0;
    end else if (enable) begin
      restart_done_reg <= restart;
      if (restart) begin
        hold_full_reg <= 1'b0;
      end else if (start && !hold_full_reg &&
                   (state_reg != ST_IDLE) && (state_reg != ST_DONE)) begin
        hold_reg      <= data;
        hold_full_reg <= 1'b1;
      end
    end
  end
`else
  assign restart   = 1'b0;
  assign load_word = data;
  assign done_next = (state_reg == ST_DONE);
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run),
    .clr  (accept || restart),
    .tick (bit_tick)
  );

  // Outputs are a registered decode of the current state, so tx trails
  // the state by one cycle: acceptance at edge N shows tx=0 from edge N+1.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_reg[0];
      ST_PARITY: tx_next = parity_reg;
      default:   tx_next = 1'b1;
    endcase
  end

  assign busy_next = (state_reg != ST_IDLE) && (state_reg != ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      bit_idx_reg <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (enable) begin
      tx   <= tx_next;
      busy <= busy_next;
      done <= done_next;
      if (accept || restart) begin
        // Parity is taken from the latched word, never from the line.
        shift_reg   <= load_word;
        parity_reg  <= frame_parity(load_word);
        bit_idx_reg <= '0;
        state_reg   <= ST_START;
      end else begin
        case (state_reg)
          ST_IDLE: begin
          end
          ST_START: begin
            if (bit_tick) state_reg <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_tick) begin
              shift_reg <= shift_reg >> 1;
              if (last_data) begin
                bit_idx_reg <= '0;
                state_reg   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
              end
            end
          end
          ST_PARITY: begin
            if (bit_tick) state_reg <= ST_STOP;
          end
          ST_STOP: begin
            if (bit_tick) begin
              if (last_stop) begin
                bit_idx_reg <= '0;
                state_reg   <= ST_DONE;
              end else begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
              end
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
